// File: rtl/mem88_pkg.sv
// mem88_pkg: shared constants and FSM state encoding for the mem88 bridge.
package mem88_pkg;

  // Address width of the 8088 core bus and the SRAM.
  localparam int ADDR_W = 20;

  // Default wait-state counts and the width of the counter that holds them.
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 1;
  localparam int DEF_CNT_W   = 4;

  // Two-bit state codes for the access sequencer.
  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_SAMPLE  = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  typedef enum logic [1:0] {
    S_CAPTURE = ST_CAPTURE,
    S_WAIT    = ST_WAIT,
    S_SAMPLE  = ST_SAMPLE,
    S_ACK     = ST_ACK
  } state_t;

endpackage

// File: rtl/mem88_bridge.sv
// mem88_bridge: turns each 8088 core cycle into one asynchronous-SRAM byte
// access with programmable read/write wait states, and paces the core with a
// one-cycle core_locked pulse per completed access.
// Optional build macro MEM88_READ_HIT_EN: keeps the address and byte of the
// last completed read so that a repeated read is answered in two clocks
// without touching the SRAM.
module mem88_bridge
  import mem88_pkg::*;
#(
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] core_address,
  input  logic [7:0]        core_data,
  input  logic              core_wreq,
  output logic [7:0]        core_bus,
  output logic              core_locked,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic [7:0]          bus_q, bus_d;
  logic                locked_q, locked_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                hit;

`ifdef MEM88_READ_HIT_EN
  logic [ADDR_W-1:0]   tag_q, tag_d;
  logic                valid_q, valid_d;

  // A read of the last completed read address is served from core_bus.
  assign hit = ~core_wreq & valid_q & (tag_q == core_address);
`else
  assign hit = 1'b0;
`endif

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    bus_d    = bus_q;
    locked_d = 1'b0;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    dq_oe_d  = dq_oe_q;
`ifdef MEM88_READ_HIT_EN
    tag_d    = tag_q;
    valid_d  = valid_q;
`endif
    case (state_q)
      S_CAPTURE: begin
        addr_d = core_address;
        dout_d = core_data;
        wr_d   = core_wreq;
        if (hit) begin
          locked_d = 1'b1;
          state_d  = S_ACK;
        end else if (core_wreq) begin
          cnt_d   = WR_LOAD;
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          state_d = (WR_LOAD == '0) ? S_SAMPLE : S_WAIT;
        end else begin
          cnt_d   = RD_LOAD;
          oe_n_d  = 1'b0;
          state_d = (RD_LOAD == '0) ? S_SAMPLE : S_WAIT;
        end
`ifdef MEM88_READ_HIT_EN
        if (core_wreq) begin
          valid_d = 1'b0;
        end
`endif
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (wr_q) begin
          we_n_d = 1'b1;
        end else begin
          oe_n_d = 1'b1;
          bus_d  = sram_din;
`ifdef MEM88_READ_HIT_EN
          tag_d   = addr_q;
          valid_d = 1'b1;
`endif
        end
        locked_d = 1'b1;
        state_d  = S_ACK;
      end
      S_ACK: begin
        dq_oe_d = 1'b0;
        state_d = S_CAPTURE;
      end
      default: begin
        state_d = S_CAPTURE;
      end
    endcase
  end

  // State and registered outputs; reset drops the strobes immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_CAPTURE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      bus_q    <= 8'hFF;
      locked_q <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
`ifdef MEM88_READ_HIT_EN
      tag_q    <= '0;
      valid_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      bus_q    <= bus_d;
      locked_q <= locked_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
`ifdef MEM88_READ_HIT_EN
      tag_q    <= tag_d;
      valid_q  <= valid_d;
`endif
    end
  end

  assign core_bus    = bus_q;
  assign core_locked = locked_q;
  assign sram_addr   = addr_q;
  assign sram_dout   = dout_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_mem88_bridge.sv
// tb_mem88_bridge: randomized scoreboard bench for mem88_bridge, with a
// second zero-wait instance driven by an alternating read/write stream.
module tb_mem88_bridge;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 1;

  typedef struct {
    logic        wr;
    logic        hit;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  data;
    int          period;
    int          oe_low;
    int          we_low;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [19:0] core_address;
  logic [7:0]  core_data;
  logic        core_wreq;
  logic [7:0]  core_bus;
  logic        core_locked;
  logic [19:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  logic        z_resetn;
  logic [19:0] z_address;
  logic [7:0]  z_data;
  logic        z_wreq;
  logic [7:0]  z_bus;
  logic        z_locked;
  logic [19:0] z_sram_addr;
  logic [7:0]  z_sram_dout;
  logic [7:0]  z_sram_din;
  logic        z_dq_oe;
  logic        z_we_n;
  logic        z_oe_n;
  logic        z_done;

  int errors = 0;
  int checks = 0;

  // SRAM models: read-only base image plus a separately tracked written copy
  logic [7:0] sram_base [0:(1<<20)-1];
  logic [7:0] sram_wr   [0:(1<<20)-1];
  bit         sram_wv   [0:(1<<20)-1];
  logic [7:0] z_base [0:255];
  logic [7:0] z_wr   [0:255];
  bit         z_wv   [0:255];

  // Reference model state
  logic [7:0]  ref_mem [logic [19:0]];
  logic [7:0]  z_ref   [0:255];
  logic [7:0]  m_bus;
`ifdef MEM88_READ_HIT_EN
  logic [19:0] m_tag;
  logic        m_valid;
`endif
  exp_t        exp_q [$];
  logic [19:0] pool [0:3];

  // Monitor state
  int          cyc = 0;
  int          last_lock = 0;
  int          oe_cnt = 0;
  int          we_cnt = 0;
  bit          overlap = 0;
  bit          moved = 0;
  bit          prev_strobe = 0;
  logic [27:0] prev_bus = '0;

  mem88_bridge #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .CNT_W(4)) u_dut (
    .clock(clock), .resetn(resetn),
    .core_address(core_address), .core_data(core_data), .core_wreq(core_wreq),
    .core_bus(core_bus), .core_locked(core_locked),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  mem88_bridge #(.RD_WAIT(0), .WR_WAIT(0), .CNT_W(4)) u_dut_zero (
    .clock(clock), .resetn(z_resetn),
    .core_address(z_address), .core_data(z_data), .core_wreq(z_wreq),
    .core_bus(z_bus), .core_locked(z_locked),
    .sram_addr(z_sram_addr), .sram_dout(z_sram_dout), .sram_din(z_sram_din),
    .sram_dq_oe(z_dq_oe), .sram_we_n(z_we_n), .sram_oe_n(z_oe_n)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM: combinational read, write while WE_n is low
  assign sram_din = sram_wv[sram_addr] ? sram_wr[sram_addr] : sram_base[sram_addr];

  always @(posedge clock) begin
    if (!sram_we_n && sram_dq_oe) begin
      sram_wr[sram_addr] <= sram_dout;
      sram_wv[sram_addr] <= 1'b1;
    end
  end

  assign z_sram_din = (z_sram_addr[19:8] != 12'h0) ? 8'h00 :
                      (z_wv[z_sram_addr[7:0]] ? z_wr[z_sram_addr[7:0]] : z_base[z_sram_addr[7:0]]);

  always @(posedge clock) begin
    if (!z_we_n && z_dq_oe && z_sram_addr[19:8] == 12'h0) begin
      z_wr[z_sram_addr[7:0]] <= z_sram_dout;
      z_wv[z_sram_addr[7:0]] <= 1'b1;
    end
  end

  function automatic logic [7:0] init_byte(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'h96;
  endfunction

  function automatic logic [7:0] ref_read(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic preload(input logic [19:0] a, input logic [7:0] v);
    sram_base[a] = v;
    ref_mem[a]   = v;
  endtask

  // Issue one core access, queue its expected outcome, wait for the locked pulse
  task automatic applyStimulus(input logic wr, input logic [19:0] a, input logic [7:0] d);
    exp_t e;
    logic hit;
    bit   seen;
    hit = 1'b0;
`ifdef MEM88_READ_HIT_EN
    hit = !wr && m_valid && (m_tag == a);
`endif
    e.wr = wr; e.hit = hit; e.addr = a; e.wdata = d;
    if (wr) begin
      ref_mem[a] = d;
      e.data   = m_bus;
      e.period = 3 + WR_WAIT;
      e.oe_low = 0;
      e.we_low = 1 + WR_WAIT;
`ifdef MEM88_READ_HIT_EN
      m_valid = 1'b0;
`endif
    end else begin
      e.data   = ref_read(a);
      m_bus    = e.data;
      e.period = hit ? 2 : 3 + RD_WAIT;
      e.oe_low = hit ? 0 : 1 + RD_WAIT;
      e.we_low = 0;
`ifdef MEM88_READ_HIT_EN
      m_tag   = a;
      m_valid = 1'b1;
`endif
    end
    exp_q.push_back(e);
    core_wreq    = wr;
    core_address = a;
    core_data    = d;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (core_locked) seen = 1;
    end
    if (!seen) checkOutput("lock_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: measures each access between locked pulses and scores it
  always @(negedge clock) begin : monitor
    exp_t e;
    logic strobe;
    cyc++;
    strobe = !sram_oe_n || !sram_we_n;
    if (!resetn) begin
      last_lock = cyc;
      oe_cnt = 0; we_cnt = 0; overlap = 0; moved = 0;
    end else begin
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (!sram_oe_n && !sram_we_n) overlap = 1;
      if (strobe && prev_strobe && ({sram_addr, sram_dout} != prev_bus)) moved = 1;
      if (core_locked) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_locked", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput(e.wr ? "wr_period" : (e.hit ? "hit_period" : "rd_period"),
                      32'(cyc - last_lock), 32'(e.period));
          checkOutput(e.wr ? "wr_core_bus_kept" : "rd_core_bus", {24'h0, core_bus}, {24'h0, e.data});
          checkOutput("oe_low_cycles", 32'(oe_cnt), 32'(e.oe_low));
          checkOutput("we_low_cycles", 32'(we_cnt), 32'(e.we_low));
          checkOutput("strobe_overlap", {31'h0, overlap}, 32'd0);
          checkOutput("bus_moved_under_strobe", {31'h0, moved}, 32'd0);
          if (!e.hit) checkOutput("sram_addr", {12'h0, sram_addr}, {12'h0, e.addr});
          if (e.wr) checkOutput("sram_dout", {24'h0, sram_dout}, {24'h0, e.wdata});
        end
        last_lock = cyc;
        oe_cnt = 0; we_cnt = 0; overlap = 0; moved = 0;
      end
    end
    prev_strobe = strobe;
    prev_bus = {sram_addr, sram_dout};
  end

  // Zero-wait instance: alternating read/write stream, 3-clock period each
  initial begin : zero_wait
    logic [19:0] a;
    logic [7:0]  d;
    logic [7:0]  want;
    logic        wr;
    bit          seen;
    bit          ov;
    int          n;
    z_done = 0;
    z_resetn = 1; z_wreq = 0; z_address = '0; z_data = '0;
    for (int i = 0; i < 256; i++) begin
      z_base[i] = init_byte(20'(i));
      z_ref[i]  = init_byte(20'(i));
    end
    #2 z_resetn = 0;
    repeat (3) @(posedge clock);
    #1 z_resetn = 1;
    for (int i = 0; i < 24; i++) begin
      wr = i[0];
      a  = {12'h0, 8'($urandom_range(0, 255))};
      d  = 8'($urandom);
      want = z_ref[a[7:0]];
      if (wr) z_ref[a[7:0]] = d;
      z_wreq = wr; z_address = a; z_data = d;
      n = 0; seen = 0; ov = 0;
      while (!seen && n < 10) begin
        @(negedge clock);
        n++;
        if (!z_oe_n && !z_we_n) ov = 1;
        if (z_locked) seen = 1;
      end
      checkOutput("zw_period", 32'(n), 32'd3);
      checkOutput("zw_overlap", {31'h0, ov}, 32'd0);
      if (!wr) checkOutput("zw_read_data", {24'h0, z_bus}, {24'h0, want});
    end
    z_done = 1;
  end

  // Main sequence: reset, directed accesses, mid-access reset, random stream
  initial begin : main_seq
    logic        wr;
    logic [19:0] a;
    clock = 0;
    resetn = 1;
    core_wreq = 0; core_address = '0; core_data = '0;
    m_bus = 8'hFF;
`ifdef MEM88_READ_HIT_EN
    m_valid = 1'b0;
    m_tag = '0;
`endif
    for (int i = 0; i < (1 << 20); i++) sram_base[i] = init_byte(20'(i));
    preload(20'hFFFF0, 8'h5A);
    preload(20'h12345, 8'h77);
    preload(20'hFFFFF, 8'hE1);
    preload(20'h00000, 8'h1E);
    pool[0] = 20'h12345; pool[1] = 20'hFFFFF; pool[2] = 20'h00000; pool[3] = 20'h00400;

    #2 resetn = 0;
    #1;
    checkOutput("rst_core_locked", {31'h0, core_locked}, 32'd0);
    checkOutput("rst_core_bus", {24'h0, core_bus}, 32'hFF);
    checkOutput("rst_we_n", {31'h0, sram_we_n}, 32'd1);
    checkOutput("rst_oe_n", {31'h0, sram_oe_n}, 32'd1);
    checkOutput("rst_dq_oe", {31'h0, sram_dq_oe}, 32'd0);
    checkOutput("rst_sram_addr", {12'h0, sram_addr}, 32'd0);
    checkOutput("rst_sram_dout", {24'h0, sram_dout}, 32'd0);
    repeat (3) @(posedge clock);
    #1 resetn = 1;

    applyStimulus(1'b0, 20'hFFFF0, 8'h00);
    applyStimulus(1'b1, 20'h00400, 8'hC3);
    applyStimulus(1'b0, 20'h00400, 8'h00);
    applyStimulus(1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b1, 20'h00800, 8'h11);
    applyStimulus(1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b0, 20'hFFFFF, 8'h00);
    applyStimulus(1'b0, 20'h00000, 8'h00);

    core_wreq = 1; core_address = 20'h0A5A5; core_data = 8'h3C;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_we_active", {31'h0, sram_we_n}, 32'd0);
    resetn = 0;
    #1;
    checkOutput("abort_we_n", {31'h0, sram_we_n}, 32'd1);
    checkOutput("abort_dq_oe", {31'h0, sram_dq_oe}, 32'd0);
    checkOutput("abort_locked", {31'h0, core_locked}, 32'd0);
    checkOutput("abort_core_bus", {24'h0, core_bus}, 32'hFF);
    m_bus = 8'hFF;
`ifdef MEM88_READ_HIT_EN
    m_valid = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1 resetn = 1;
    applyStimulus(1'b1, 20'h00401, 8'h5C);
    applyStimulus(1'b0, 20'h00401, 8'h00);

    for (int i = 0; i < 60; i++) begin
      wr = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 2) == 0) a = 20'($urandom);
      else a = pool[$urandom_range(0, 3)];
      applyStimulus(wr, a, 8'($urandom));
    end

    for (int n = 0; n < 2000 && !z_done; n++) @(negedge clock);
    checkOutput("zero_wait_done", {31'h0, z_done}, 32'd1);
    repeat (2) @(negedge clock);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem88_bridge.md
Name: mem88_bridge

Overview:
- Bus bridge directly downstream of the 8088 core.
- Each core cycle presents a 20-bit address, a write strobe and a write byte. The bridge turns that into one asynchronous-SRAM byte access with a programmable number of wait states.
- It returns read data on the core's byte bus and paces the core through its `locked` input: one core step per completed memory access.

Parameters:
- RD_WAIT, 2: extra SRAM cycles held before a read is sampled (0..15).
- WR_WAIT, 1: extra SRAM cycles WE_n stays low on a write (0..15).
- CNT_W, 4: wait-counter width; must hold max(RD_WAIT, WR_WAIT).

Ports:
- clock in 1: single system clock; all logic on its rising edge.
- resetn in 1: asynchronous, active-low reset.
- core_address in 20: byte address from the core.
- core_data in 8: write byte from the core.
- core_wreq in 1: 1 = write, 0 = read.
- core_bus out 8: read byte to the core; valid while core_locked = 1.
- core_locked out 1: 1-cycle advance pulse to the core.
- sram_addr out 20: SRAM address.
- sram_dout out 8: SRAM write data.
- sram_din in 8: SRAM read data.
- sram_dq_oe out 1: 1 = bridge drives the SRAM data lines.
- sram_we_n out 1: SRAM write enable, active low.
- sram_oe_n out 1: SRAM output enable, active low.

Behaviour:
- Reset values (asynchronous, immediate):
  - core_locked = 0, core_bus = 8'hFF.
  - sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0.
  - sram_addr = 0, sram_dout = 0.
  - state = CAPTURE, counter = 0.
- State CAPTURE:
  - Latch core_address, core_wreq and core_data into sram_addr/sram_dout.
  - Load counter with RD_WAIT or WR_WAIT.
  - Read: sram_oe_n = 0. Write: sram_dq_oe = 1, sram_we_n = 0.
  - Next state: WAIT, or SAMPLE if the counter load is 0.
- State WAIT:
  - Decrement counter; strobes held.
  - At 0 go to SAMPLE.
- State SAMPLE:
  - Read: core_bus <= sram_din; sram_oe_n = 1.
  - Write: sram_we_n = 1; sram_dq_oe stays 1 this cycle (hold time).
  - Next state: ACK.
- State ACK:
  - core_locked = 1 for exactly this cycle; core_bus stable.
  - sram_dq_oe = 0.
  - Next state: CAPTURE.
- Timing:
  - Core-visible period = 3 + wait cycles: read 5 clocks, write 4 clocks with defaults; 3 clocks with zero waits.
  - Address and strobes never change while a strobe is asserted.
  - sram_we_n and sram_oe_n are never low together.
  - core_locked is never high on two consecutive cycles.
- Sampling window:
  - core_address/core_wreq/core_data are sampled only in CAPTURE.
  - Changes elsewhere are ignored; the core only changes them after a locked pulse.
- Address wrap:
  - 20-bit only; FFFFF is a normal address.
  - The core's segment:offset overflow is already truncated upstream.
- Reset mid-access:
  - Strobes deassert asynchronously; no locked pulse is issued.
  - After release, the first access begins in CAPTURE on the next edge.
- core_bus keeps its last read value across writes.

Optional Feature:
- Macro: MEM88_READ_HIT_EN.
- Defined:
  - A 20-bit last-read tag and a valid bit are kept.
  - A read in CAPTURE whose address equals the tag while valid is a hit. It skips WAIT and SAMPLE and goes straight to ACK with the stored byte; SRAM strobes stay inactive.
  - Hit period is 2 clocks.
  - Any write clears valid; reset clears valid.
  - A completed read sets the tag and valid.
- Undefined: every access goes to SRAM exactly as above; no tag logic is synthesised.

Decomposition:
- Package mem88_pkg:
  - State encoding (CAPTURE, WAIT, SAMPLE, ACK as 2-bit localparams).
  - Default wait constants.
  - Address width 20.
- No sub-module needed. The wait counter and the hit tag stay inline; a single FSM file is sufficient.

Test Plan:
- Read, defaults: sram holds 8'h5A at 20'hFFFF0; core_address = 20'hFFFF0, wreq 0.
  - oe_n low for 3 clocks.
  - core_locked pulses on clock 5 with core_bus = 8'h5A.
  - we_n high throughout.
- Write, defaults: core_address = 20'h00400, data 8'hC3, wreq 1.
  - we_n low for exactly 2 clocks with sram_addr = 20'h00400 and sram_dout = 8'hC3.
  - locked pulse on clock 4.
  - sram reads back 8'hC3.
- Zero waits (RD_WAIT = 0, WR_WAIT = 0), alternating read/write stream: locked pulses every 3 clocks; oe_n and we_n never overlap.
- Reset mid-access: assert resetn = 0 during WAIT of a write.
  - we_n = 1 and dq_oe = 0 within the same cycle.
  - No locked pulse.
  - After release, the next access completes normally.
- Hit feature (MEM88_READ_HIT_EN):
  - Two reads of 20'h12345 (byte 8'h77): second read acks after 2 clocks with 8'h77 and no oe_n activity.
  - A write to any address, then a third read of 20'h12345: full 5-clock access.
- Boundary address: read at 20'hFFFFF returns its byte; the next read at 20'h00000 is independent and correct.
